// File: rtl/md5_pkg.sv
// MD5 shared constants: round constants, shift table, IV and FSM states.
// Helpers map a step index to its shift amount and message word index.
package md5_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINAL
  } state_e;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // One row per round; the leftmost field is the shift for i mod 4 = 0.
  localparam logic [19:0] S_ROW [4] = '{
    {5'd7, 5'd12, 5'd17, 5'd22},
    {5'd5, 5'd9,  5'd14, 5'd20},
    {5'd4, 5'd11, 5'd16, 5'd23},
    {5'd6, 5'd10, 5'd15, 5'd21}
  };

  function automatic logic [4:0] shamt(input logic [5:0] i);
    logic [19:0] row;
    row = S_ROW[i[5:4]];
    return row[5'(3 - i[1:0]) * 5 +: 5];
  endfunction

  // Multipliers only matter mod 16, so i[3:0] suffices.
  function automatic logic [3:0] msg_idx(input logic [5:0] i);
    logic [3:0] j;
    logic [3:0] g;
    j = i[3:0];
    g = j;
    unique case (i[5:4])
      2'd0: g = j;
      2'd1: g = 4'(j * 4'd5 + 4'd1);
      2'd2: g = 4'(j * 4'd3 + 4'd5);
      2'd3: g = 4'(j * 4'd7);
    endcase
    return g;
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/md5_hash_core_step.sv
// One combinational MD5 round step: a,b,c,d plus M[g] and step index
// i in, rotated working state out.
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] m_i,
  input  logic [5:0]  i_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);

  logic [31:0] f;
  logic [31:0] sum;
  logic [31:0] rot;
  logic [4:0]  sh;

  always_comb begin
    f = '0;
    unique case (i_i[5:4])
      2'd0: f = (b_i & c_i) | (~b_i & d_i);
      2'd1: f = (d_i & b_i) | (~d_i & c_i);
      2'd2: f = b_i ^ c_i ^ d_i;
      2'd3: f = c_i ^ (b_i | ~d_i);
    endcase
  end

  assign sum = a_i + f + K_TAB[i_i] + m_i;
  assign sh  = shamt(i_i);
  // Shift amounts are never 0, so 32-sh stays in 1..31.
  assign rot = (sum << sh) | (sum >> (6'd32 - {1'b0, sh}));

  assign a_o = d_i;
  assign b_o = b_i + rot;
  assign c_o = b_i;
  assign d_o = c_i;

endmodule

// File: rtl/md5_hash_core.sv
// Single-block MD5 engine: start/resume latch a 512-bit block, 64 steps
// run one per clock, FINAL adds into H. Ports: clk, rst (sync, low),
// start, resume, input_data[0:511] in; hash[0:127], done out.
module md5_hash_core
  import md5_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         resume,
  input  logic [0:511] input_data,
  output logic [0:127] hash,
  output logic         done
);

  state_e      state_q;
  logic [5:0]  i_q;
  logic        done_q;
  logic [31:0] m_q [16];
  logic [31:0] a_q, b_q, c_q, d_q;
  logic [31:0] ha_q, hb_q, hc_q, hd_q;
  logic [31:0] a_d, b_d, c_d, d_d;

  md5_step u_step (
    .a_i (a_q),
    .b_i (b_q),
    .c_i (c_q),
    .d_i (d_q),
    .m_i (m_q[msg_idx(i_q)]),
    .i_i (i_q),
    .a_o (a_d),
    .b_o (b_d),
    .c_o (c_d),
    .d_o (d_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      done_q  <= 1'b0;
      ha_q    <= IV_A;
      hb_q    <= IV_B;
      hc_q    <= IV_C;
      hd_q    <= IV_D;
      a_q     <= IV_A;
      b_q     <= IV_B;
      c_q     <= IV_C;
      d_q     <= IV_D;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start || resume) begin
            // Byte k sits at input_data[8k +: 8]; words are little-endian.
            for (int j = 0; j < 16; j++) begin
              m_q[j] <= {input_data[32*j+24 +: 8],
                         input_data[32*j+16 +: 8],
                         input_data[32*j+8  +: 8],
                         input_data[32*j    +: 8]};
            end
            i_q     <= '0;
            done_q  <= 1'b0;
            state_q <= RUN;
            if (start) begin
              ha_q <= IV_A;
              hb_q <= IV_B;
              hc_q <= IV_C;
              hd_q <= IV_D;
              a_q  <= IV_A;
              b_q  <= IV_B;
              c_q  <= IV_C;
              d_q  <= IV_D;
            end else begin
              a_q <= ha_q;
              b_q <= hb_q;
              c_q <= hc_q;
              d_q <= hd_q;
            end
          end
        end
        RUN: begin
          a_q <= a_d;
          b_q <= b_d;
          c_q <= c_d;
          d_q <= d_d;
          i_q <= i_q + 6'd1;
          if (i_q == 6'd63) state_q <= FINAL;
        end
        FINAL: begin
          ha_q    <= ha_q + a_q;
          hb_q    <= hb_q + b_q;
          hc_q    <= hc_q + c_q;
          hd_q    <= hd_q + d_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hash = {bswap(ha_q), bswap(hb_q), bswap(hc_q), bswap(hd_q)};
  assign done = done_q;

endmodule

// File: tb/tb_md5_hash_core.sv
// Bench for md5_hash_core: vector table, corner sequences and random
// chained blocks against a padded-message MD5 reference model.
module tb_md5_hash_core;

  typedef logic [3:0][31:0] cv_t;

  typedef struct {
    logic [0:511] blk;
    bit           st;
    bit           rs;
    logic [0:127] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         resume = 1'b0;
  logic [0:511] input_data = '0;
  logic [0:127] hash;
  logic         done;

  int checks = 0;
  int errors = 0;

  int unsigned kt [64];
  int sh [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20},
                    '{4, 11, 16, 23}, '{6, 10, 15, 21}};
  cv_t iv;
  cv_t cv;

  md5_hash_core dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .resume     (resume),
    .input_data (input_data),
    .hash       (hash),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name,
                     input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned rotl(input int unsigned x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic cv_t compress(input cv_t h, input logic [0:511] blk);
    int unsigned m [16];
    int unsigned a, b, c, d, f, t;
    int g;
    cv_t r;
    for (int j = 0; j < 16; j++)
      for (int k = 0; k < 4; k++)
        m[j][8*k +: 8] = blk[8*(4*j+k) +: 8];
    a = h[0]; b = h[1]; c = h[2]; d = h[3];
    for (int i = 0; i < 64; i++) begin
      if (i < 16) begin
        f = (b & c) | (~b & d); g = i;
      end else if (i < 32) begin
        f = (d & b) | (~d & c); g = (5*i + 1) % 16;
      end else if (i < 48) begin
        f = b ^ c ^ d; g = (3*i + 5) % 16;
      end else begin
        f = c ^ (b | ~d); g = (7*i) % 16;
      end
      t = d; d = c; c = b;
      b = b + rotl(a + f + kt[i] + m[g], sh[i/16][i%4]);
      a = t;
    end
    r[0] = h[0] + a; r[1] = h[1] + b;
    r[2] = h[2] + c; r[3] = h[3] + d;
    return r;
  endfunction

  function automatic logic [0:127] to_hash(input cv_t h);
    logic [0:127] v;
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      w = h[i];
      for (int k = 0; k < 4; k++) v[32*i+8*k +: 8] = w[8*k +: 8];
    end
    return v;
  endfunction

  function automatic cv_t md5_msg(input logic [7:0] msg [$]);
    logic [7:0] q [$];
    longint unsigned bits;
    logic [0:511] blk;
    cv_t h;
    q = msg;
    bits = 64'(msg.size()) * 8;
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    for (int k = 0; k < 8; k++) q.push_back(bits[8*k +: 8]);
    h = iv;
    for (int b = 0; b < q.size() / 64; b++) begin
      for (int k = 0; k < 64; k++) blk[8*k +: 8] = q[64*b + k];
      h = compress(h, blk);
    end
    return h;
  endfunction

  function automatic logic [0:511] rand_blk();
    logic [0:511] b;
    for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom;
    return b;
  endfunction

  task automatic run_cmd(input bit st, input bit rs, input logic [0:511] blk,
                         input logic [0:127] exp, input bit disturb,
                         input string name);
    logic [0:127] pre;
    int n;
    bit moved;
    pre = st ? to_hash(iv) : to_hash(cv);
    @(negedge clk);
    start = st; resume = rs; input_data = blk;
    @(posedge clk); #1;
    start = 0; resume = 0; input_data = rand_blk();
    chk(done == 1'b0, {name, " done_drop"}, 128'(done), 128'(0));
    n = 0; moved = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (disturb) begin
        start  = (n == 10);
        resume = (n == 20);
        input_data = rand_blk();
      end
      if (done) break;
      if (hash !== pre) moved = 1;
    end
    start = 0; resume = 0;
    chk(n == 65, {name, " latency"}, 128'(n), 128'(65));
    chk(!moved, {name, " hash_hold"}, 128'(moved), 128'(0));
    chk(hash === exp, {name, " digest"}, hash, exp);
    cv = compress(st ? iv : cv, blk);
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk(done == 1'b0, {name, " rst_done"}, 128'(done), 128'(0));
    chk(hash === 128'h0123456789abcdeffedcba9876543210, {name, " rst_hash"},
        hash, 128'h0123456789abcdeffedcba9876543210);
    rst = 1;
    cv = iv;
  endtask

  initial begin
    logic [0:511] b_empty, b_abc, b_x1, b_x2, b;
    logic [7:0] xmsg [$];
    logic [0:127] d_empty, d_abc;
    vec_t tv [4];
    bit st;
    real x;

    for (int i = 0; i < 64; i++) begin
      x = $sin(real'(i + 1));
      if (x < 0.0) x = -x;
      kt[i] = 32'(longint'($floor(x * 4294967296.0)));
    end
    iv[0] = 32'h67452301; iv[1] = 32'hefcdab89;
    iv[2] = 32'h98badcfe; iv[3] = 32'h10325476;
    cv = iv;

    d_empty = 128'hd41d8cd98f00b204e9800998ecf8427e;
    d_abc   = 128'h900150983cd24fb0d6963f7d28e17f72;

    b_empty = '0; b_empty[0:7] = 8'h80;
    b_abc = '0;
    b_abc[0:7] = 8'h61; b_abc[8:15] = 8'h62; b_abc[16:23] = 8'h63;
    b_abc[24:31] = 8'h80; b_abc[448:455] = 8'h18;
    b_x1 = '0;
    for (int k = 0; k < 64; k++) b_x1[8*k +: 8] = 8'h58;
    b_x2 = '0;
    for (int k = 0; k < 36; k++) b_x2[8*k +: 8] = 8'h58;
    b_x2[288:295] = 8'h80;
    b_x2[448:455] = 8'h20; b_x2[456:463] = 8'h03;
    for (int k = 0; k < 100; k++) xmsg.push_back(8'h58);

    tv[0] = '{b_empty, 1'b1, 1'b0, d_empty};
    tv[1] = '{b_abc,   1'b1, 1'b0, d_abc};
    tv[2] = '{b_x1,    1'b1, 1'b0, to_hash(compress(iv, b_x1))};
    tv[3] = '{b_x2,    1'b0, 1'b1, to_hash(md5_msg(xmsg))};

    repeat (2) @(posedge clk);
    #1;
    chk(done == 1'b0, "reset done", 128'(done), 128'(0));
    chk(hash === to_hash(iv), "reset hash", hash, to_hash(iv));
    rst = 1;

    for (int v = 0; v < 4; v++)
      run_cmd(tv[v].st, tv[v].rs, tv[v].blk, tv[v].exp, 1'b0,
              $sformatf("vec%0d", v));

    run_cmd(1'b1, 1'b0, b_abc, d_abc, 1'b1, "disturb");

    @(negedge clk); start = 1; input_data = b_abc;
    @(posedge clk); #1; start = 0;
    repeat (30) @(posedge clk);
    pulse_reset("midrst");
    run_cmd(1'b1, 1'b0, b_abc, d_abc, 1'b0, "after_rst");

    run_cmd(1'b1, 1'b1, b_empty, d_empty, 1'b0, "both");

    pulse_reset("rst2");
    b = rand_blk();
    run_cmd(1'b0, 1'b1, b, to_hash(compress(iv, b)), 1'b0, "resume_iv");

    for (int r = 0; r < 6; r++) begin
      b = rand_blk();
      st = ($urandom_range(0, 2) == 0);
      run_cmd(st, !st, b, to_hash(compress(st ? iv : cv, b)), 1'b0,
              $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md5_hash_core.md
# md5_hash_core

Single-block MD5 compression engine (RFC 1321): absorbs one 512-bit pre-padded message block per command and updates a 128-bit chaining value. `start` begins a new message from the MD5 IV; `resume` chains a further block onto the current value. Padding and length encoding are done by the surrounding logic. One round step runs per clock.

## Interface
- No parameters.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle pulse: load `input_data`, initialise the chaining value to the IV, hash the block.
- `resume`  in  1  single-cycle pulse: load `input_data`, hash the block onto the current chaining value.
- `input_data`  in  [0:511]  message block. Byte k = `input_data[8k:8k+7]`, k = 0..63, in message order.
- `hash`  out  [0:127]  digest / chaining value in standard MD5 byte order; byte 0 = `hash[0:7]` = low byte of A.
- `done`  out  1  level signal: the current block is finished and `hash` is valid.

## Operation
- States:
  - IDLE: waiting for a command.
  - RUN: 64 round steps, step counter `i` = 0..63.
  - FINAL: chaining add.
- IDLE:
  - `start` = 1: latch the block, set H = IV, set A..D = IV, clear `done`, go to RUN.
  - `resume` = 1: latch the block, set A..D = H, clear `done`, go to RUN.
  - Both asserted together: `start` wins.
- Message words: M[j] = little-endian bytes 4j..4j+3, so M[j] = {b(4j+3), b(4j+2), b(4j+1), b(4j)}.
- RUN step i, standard MD5:
  - F, g:
    - i 0-15: F = (B&C)|(~B&D), g = i.
    - i 16-31: F = (D&B)|(~D&C), g = (5i+1) mod 16.
    - i 32-47: F = B^C^D, g = (3i+5) mod 16.
    - i 48-63: F = C^(B|~D), g = 7i mod 16.
  - Update: tmp = D; D = C; C = B; B = B + rotl(A + F + K[i] + M[g], s[i]); A = tmp.
  - All additions are modulo 2^32.
- FINAL: H = H + {A,B,C,D}, word-wise mod 2^32. Set `done` = 1 and return to IDLE.
- `hash` = H with each 32-bit word byte-swapped to little-endian, in order A, B, C, D.
- IV: A = 67452301, B = efcdab89, C = 98badcfe, D = 10325476.
- `start` or `resume` while in RUN/FINAL: ignored.
- `input_data` is sampled only on the accepting edge and may change afterwards.

## Timing
- Accepting edge = E0. Steps occur on edges E1..E64. FINAL occurs on E65.
- `done` = 1 and `hash` updated after E65: latency 65 cycles.
- A new command is accepted from the cycle after E65.
- `done` stays high in IDLE until the next accepted command. It drops on the accepting edge.
- `hash` changes only at FINAL, on `start` (reloaded to IV), and on reset.
- Reset (`rst` = 0 at any edge, including mid-block):
  - state → IDLE, `done` = 0, H = IV, so `hash` = 0123456789abcdeffedcba9876543210.
  - The block in progress is abandoned.
- `resume` after reset with no prior `start` hashes onto the IV.

## Structure
- Package `md5_pkg`:
  - K[0:63] constant table.
  - Shift table s = {7,12,17,22}, {5,9,14,20}, {4,11,16,23}, {6,10,15,21}, each group repeated ×4.
  - IV constants.
  - State enum {IDLE, RUN, FINAL}.
- Sub-module `md5_step`: combinational single round. Inputs: A, B, C, D, M-word, i. Outputs: next A, B, C, D.
- Top level holds the FSM, counter, block register, working registers and H.

## Test plan
- Empty message: `start` with block 80 followed by 63×00 bytes → `done` at cycle 65, `hash` = d41d8cd98f00b204e9800998ecf8427e.
- "abc": `start` with block 616263 80 00…00, byte 56 = 18, rest 00 → `hash` = 900150983cd24fb0d6963f7d28e17f72.
- 100 × 'X', two blocks:
  - Block 1: 64×58, sent with `start`.
  - Block 2: 36×58, 80, zeros, length bytes 20 03 00 00 00 00 00 00, sent with `resume` after `done`.
  - Required response: `hash` equals a software MD5 of the 100-byte string, each block taking 65 cycles.
- Pulse `start`/`resume` mid-block, and change `input_data` after acceptance → both ignored; result unchanged from the "abc" case.
- Assert `rst` = 0 at step 30 → next cycle `done` = 0 and `hash` = IV. A subsequent `start` with "abc" gives the correct digest.
- Assert `start` and `resume` together with the empty-message block → digest d41d8cd98f00b204e9800998ecf8427e, i.e. `start` priority.
